// File: rtl/alu_ctrl_pkg.sv
// Shared types for alu_arb_ctrl: default widths, FSM state encoding and the
// captured response bundle.
package alu_ctrl_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int OPW_DEF   = 4;

  // 2'b11 is unused; the FSM treats it as a fault and falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_e;

  // Result field is sized for the default width; narrower builds use its low bits.
  typedef struct packed {
    logic                 id;
    logic [WIDTH_DEF-1:0] o;
    logic                 cout;
    logic                 oflow;
    logic                 ntive;
    logic                 zero;
  } rsp_t;

endpackage

// File: rtl/alu_arb_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin grant selection. The pointer names the requester
// favoured on a tie; advancing it is left to the owner of the pointer.
module rr_arb2
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic       grant_idx,
  output logic       grant_valid
);

  always_comb begin
    grant_idx   = 1'b0;
    grant_valid = 1'b0;
    if (en) begin
      case (req)
        2'b01: begin
          grant_idx   = 1'b0;
          grant_valid = 1'b1;
        end
        2'b10: begin
          grant_idx   = 1'b1;
          grant_valid = 1'b1;
        end
        2'b11: begin
          grant_idx   = ptr;
          grant_valid = 1'b1;
        end
        default: begin
          grant_idx   = 1'b0;
          grant_valid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_arb_ctrl.sv
// alu_arb_ctrl: shares one external combinational ALU between two requesters.
// Define ALU_STICKY_OFLOW_EN to add per-requester sticky overflow flags.
//   state | meaning
//   IDLE  | arbitrate and accept one request
//   ISSUE | operands drive the ALU; result captured at end of cycle
//   RESP  | response presented and held until rsp_ready
module alu_arb_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r0_cin,
  input  logic [OPW-1:0]   r0_s,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic             r1_cin,
  input  logic [OPW-1:0]   r1_s,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [OPW-1:0]   alu_s,
  input  logic [WIDTH-1:0] alu_o,
  input  logic             alu_cout,
  input  logic             alu_oflow,
  input  logic             alu_ntive,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_o,
  output logic             rsp_cout,
  output logic             rsp_oflow,
  output logic             rsp_ntive,
  output logic             rsp_zero,
  output logic             busy
`ifdef ALU_STICKY_OFLOW_EN
  ,
  input  logic             sticky_clr,
  output logic             r0_oflow_sticky,
  output logic             r1_oflow_sticky
`endif
);

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic [OPW-1:0]   alu_s_q, alu_s_d;
  rsp_t             rsp_q, rsp_d;

  logic             arb_en;
  logic             grant_idx;
  logic             grant_valid;
  logic             rsp_hs;

  // Nothing is accepted while reset is asserted, even though the FSM already sits in IDLE.
  assign arb_en = (state_q == IDLE) && rst_n;

  rr_arb2 u_arb (
    .req         ({r1_valid, r0_valid}),
    .ptr         (rr_ptr_q),
    .en          (arb_en),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign r0_ready = grant_valid & ~grant_idx;
  assign r1_ready = grant_valid &  grant_idx;

  assign rsp_hs   = (state_q == RESP) && rsp_ready;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_cin_d = alu_cin_q;
    alu_s_d   = alu_s_q;
    rsp_d     = rsp_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          alu_a_d   = grant_idx ? r1_a   : r0_a;
          alu_b_d   = grant_idx ? r1_b   : r0_b;
          alu_cin_d = grant_idx ? r1_cin : r0_cin;
          alu_s_d   = grant_idx ? r1_s   : r0_s;
          rsp_d.id  = grant_idx;
          rr_ptr_d  = ~grant_idx;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        rsp_d.o[WIDTH-1:0] = alu_o;
        rsp_d.cout         = alu_cout;
        rsp_d.oflow        = alu_oflow;
        rsp_d.ntive        = alu_ntive;
        rsp_d.zero         = alu_zero;
        state_d            = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_cin_q <= 1'b0;
      alu_s_q   <= '0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_cin_q <= alu_cin_d;
      alu_s_q   <= alu_s_d;
      rsp_q     <= rsp_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign alu_s     = alu_s_q;

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_q.id;
  assign rsp_o     = rsp_q.o[WIDTH-1:0];
  assign rsp_cout  = rsp_q.cout;
  assign rsp_oflow = rsp_q.oflow;
  assign rsp_ntive = rsp_q.ntive;
  assign rsp_zero  = rsp_q.zero;
  assign busy      = (state_q != IDLE);

`ifdef ALU_STICKY_OFLOW_EN
  logic [1:0] sticky_q, sticky_d;
  logic [1:0] sticky_set;

  assign sticky_set[0] = rsp_hs && rsp_q.oflow && (rsp_q.id == 1'b0);
  assign sticky_set[1] = rsp_hs && rsp_q.oflow && (rsp_q.id == 1'b1);

  // A set in the same cycle as a clear wins, so an overflow is never lost.
  assign sticky_d = sticky_set | (sticky_q & ~{2{sticky_clr}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 2'b00;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign r0_oflow_sticky = sticky_q[0];
  assign r1_oflow_sticky = sticky_q[1];
`endif

endmodule
